// File: rtl/bcd_display_driver_pkg.sv
// Shared constants for the two-digit seven-segment display driver:
// scan FSM state encoding and the segment patterns {g,f,e,d,c,b,a}.
package bcd_display_driver_pkg;

    // Scan states, visited in this fixed order every frame
    localparam logic [1:0] BLANK_T = 2'd0;
    localparam logic [1:0] SHOW_T  = 2'd1;
    localparam logic [1:0] BLANK_O = 2'd2;
    localparam logic [1:0] SHOW_O  = 2'd3;

    // Shown for any BCD nibble above 9
    localparam logic [6:0] SEG_DASH = 7'h40;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

endpackage

// File: rtl/bcd_display_driver_bcd_to_seg7.sv
// Combinational BCD digit to seven-segment decoder; invalid codes show a dash.
module bcd_to_seg7
    import bcd_display_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup, dash for A..F
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_driver.sv
// Two-digit multiplexed seven-segment driver with tear-free frame-boundary
// commit, anti-ghosting blank gaps, leading-zero blanking and PWM dimming.
// Optional feature: define SEG_BLINK_EN to add a frame counter that blanks
// the digits for half of every 256-frame period while blink is high.
// BLANK_CYCLES is expected to be at least 1.
module bcd_display_driver
    import bcd_display_driver_pkg::*;
#(
    parameter int SCAN_DIV     = 16,
    parameter int BLANK_CYCLES = 2,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bcd_in,
    input  logic       load,
    input  logic [2:0] bright,
    input  logic       blink,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       applied
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - BLANK_CYCLES - 1);

    logic [1:0]    state, state_d;
    logic [CW-1:0] slot_cnt, slot_cnt_d;
    logic          state_last;
    logic          commit;

    logic [7:0]    shadow, shadow_d;
    logic [7:0]    display, display_d;
    logic          pending, pending_d;
    logic          applied_q, applied_d;

    logic [6:0]    seg_q, seg_d;
    logic [1:0]    dig_q, dig_d;
    logic [3:0]    digit;
    logic [6:0]    dec_seg;
    logic          pwm_on;

`ifdef SEG_BLINK_EN
    logic [7:0]    frame_cnt;
`else
    logic          unused_blink;
    assign unused_blink = blink;
`endif

    // Scan sequencing: slot counter restarts on every state change
    always_comb begin
        if (state == BLANK_T || state == BLANK_O) begin
            state_last = (slot_cnt == BLANK_LAST);
        end else begin
            state_last = (slot_cnt == SHOW_LAST);
        end
        state_d    = state;
        slot_cnt_d = slot_cnt + CW'(1);
        if (state_last) begin
            slot_cnt_d = '0;
            case (state)
                BLANK_T: state_d = SHOW_T;
                SHOW_T:  state_d = BLANK_O;
                BLANK_O: state_d = SHOW_O;
                default: state_d = BLANK_T;
            endcase
        end
        // Frame boundary: last SHOW_O cycle
        commit = (state == SHOW_O) && state_last;
    end

    // Shadow capture and frame-boundary commit; a load on the boundary bypasses the shadow
    always_comb begin
        shadow_d  = load ? bcd_in : shadow;
        pending_d = pending;
        display_d = display;
        applied_d = 1'b0;
        if (commit) begin
            pending_d = 1'b0;
            if (pending || load) begin
                display_d = shadow_d;
                applied_d = 1'b1;
            end
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // One decoder shared by both digits, input muxed by scan state
    assign digit = (state == SHOW_T) ? display[7:4] : display[3:0];

    bcd_to_seg7 u_dec (
        .bcd (digit),
        .seg (dec_seg)
    );

    assign pwm_on = (slot_cnt[2:0] <= bright);

    // Next registered pin values decoded from the current state and counter
    always_comb begin
        seg_d = 7'h00;
        dig_d = 2'b00;
        case (state)
            SHOW_T: begin
                seg_d = dec_seg;
                // Leading zero blanking; invalid tens codes are never blanked
                dig_d = {pwm_on && (display[7:4] != 4'd0), 1'b0};
            end
            SHOW_O: begin
                seg_d = dec_seg;
                dig_d = {1'b0, pwm_on};
            end
            default: begin
                seg_d = 7'h00;
                dig_d = 2'b00;
            end
        endcase
`ifdef SEG_BLINK_EN
        if (blink && frame_cnt[7]) begin
            dig_d = 2'b00;
        end
`endif
    end

    // Scan state and slot counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BLANK_T;
            slot_cnt <= '0;
        end else begin
            state    <= state_d;
            slot_cnt <= slot_cnt_d;
        end
    end

    // Shadow, display and commit pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= 8'h00;
            display   <= 8'h00;
            pending   <= 1'b0;
            applied_q <= 1'b0;
        end else begin
            shadow    <= shadow_d;
            display   <= display_d;
            pending   <= pending_d;
            applied_q <= applied_d;
        end
    end

    // Registered segment and digit drive (logical polarity)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= 7'h00;
            dig_q <= 2'b00;
        end else begin
            seg_q <= seg_d;
            dig_q <= dig_d;
        end
    end

`ifdef SEG_BLINK_EN
    // Frame counter, advanced on every entry to BLANK_T
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 8'h00;
        end else if (commit) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

    // Pin polarity for common-anode boards; applied stays active high
    assign seg     = ACTIVE_LOW ? ~seg_q : seg_q;
    assign dig_en  = ACTIVE_LOW ? ~dig_q : dig_q;
    assign applied = applied_q;

endmodule
